// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states, column strobes,
// idle row value and small decode helpers.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_HELD     = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] KP_COL0     = 4'b0111;
    localparam logic [3:0] KP_COL1     = 4'b1011;
    localparam logic [3:0] KP_COL2     = 4'b1101;
    localparam logic [3:0] KP_COL3     = 4'b1110;
    localparam logic [3:0] KP_ROW_IDLE = 4'b1111;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = KP_COL0;
            2'd1:    pat = KP_COL1;
            2'd2:    pat = KP_COL2;
            default: pat = KP_COL3;
        endcase
        return pat;
    endfunction

    // True when exactly one active-low row bit is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        return $countones(~rows) == 1;
    endfunction

    // row[3] is row index 0, row[0] is row index 3.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] r;
        case (rows)
            4'b0111: r = 2'd0;
            4'b1011: r = 2'd1;
            4'b1101: r = 2'd2;
            4'b1110: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module row_sync
    import keypad_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] row_s
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= KP_ROW_IDLE;
            row_s <= KP_ROW_IDLE;
        end else begin
            meta  <= row;
            row_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns, debounces single-key presses and
// releases, and shifts each accepted key code into a 16-bit operand.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] num
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    kp_state_t     state, state_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    pat, pat_n;
    logic [3:0]    row_s;
    logic          fire;
    logic [3:0]    code;

    row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .row   (row),
        .row_s (row_s)
    );

    assign code = {row_index(pat), col_idx};

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        dwell_n   = dwell;
        cnt_n     = cnt;
        pat_n     = pat;
        fire      = 1'b0;
        case (state)
            KP_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (single_low(row_s)) begin
                        pat_n   = row_s;
                        cnt_n   = '0;
                        state_n = KP_DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + DW'(1);
                end
            end
            KP_DEBOUNCE: begin
                // Any glitch abandons this column; the key is picked up again on a later pass.
                if (row_s != pat) begin
                    state_n   = KP_SCAN;
                    col_idx_n = col_idx + 2'd1;
                    dwell_n   = '0;
                    cnt_n     = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = KP_HELD;
                    fire    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            KP_HELD: begin
                if (row_s == KP_ROW_IDLE) begin
                    state_n = KP_RELEASE;
                    cnt_n   = '0;
                end
            end
            KP_RELEASE: begin
                if (row_s != KP_ROW_IDLE) begin
                    state_n = KP_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n   = KP_SCAN;
                    col_idx_n = col_idx + 2'd1;
                    dwell_n   = '0;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = KP_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= KP_SCAN;
            col_idx   <= 2'd0;
            col       <= KP_COL0;
            dwell     <= '0;
            cnt       <= '0;
            pat       <= KP_ROW_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            num       <= 16'd0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            col       <= col_pattern(col_idx_n);
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            pat       <= pat_n;
            key_valid <= fire;
            if (fire)
                key_code <= code;
            // clr takes priority over a same-cycle key entry.
            if (clr)
                num <= 16'd0;
            else if (fire)
                num <= {num[11:0], code};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8 and a
// behavioural keypad that pulls a row low while the pressed key's column is strobed.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] num;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] num;

    logic [15:0] keys = 16'h0;
    logic [15:0] exp_num = 16'h0;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pulses = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .clr       (clr),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .num       (num)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] tb_col(input int c);
        logic [3:0] one;
        one = 4'b1000;
        return ~(one >> c);
    endfunction

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && col == tb_col(c))
                    row[3-r] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_num = {exp_num[11:0], code};
        sb.push_back({code, exp_num});
    endtask

    // Monitor: every key_valid pulse must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (key_valid === 1'b1) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: key_code %h num %h, expected no pulse", key_code, num);
            end else begin
                e = sb.pop_front();
                check("pulse_code", {12'h0, key_code}, {12'h0, e.code});
                check("pulse_num", num, e.num);
            end
        end
    end

    task automatic wait_col(input logic [3:0] pat);
        int n = 0;
        while (col !== pat && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", {12'h0, col}, {12'h0, pat});
    endtask

    task automatic wait_pulse(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            failures++;
            $display("FAIL pulse_timeout: no key_valid within %0d cycles, expected one", budget);
        end
    endtask

    // Press while the column after c is strobed, so detection lands on a known dwell.
    task automatic press(input int r, input int c, input int hold, input bit do_clr);
        int k;
        int at;
        wait_col(tb_col((c + 1) % 4));
        keys[4*r+c] = 1'b1;
        wait_col(tb_col(c));
        k  = cyc;
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            clr = do_clr && (cyc == k + 11);
            if (key_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        clr = 1'b0;
        check("latency", 16'(at - k), 16'd12);
        repeat (hold) @(negedge clk);
        keys[4*r+c] = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int p0;
        int at;
        repeat (3) @(negedge clk);
        check("rst_col", {12'h0, col}, 16'h0007);
        check("rst_valid", {15'h0, key_valid}, 16'h0);
        check("rst_code", {12'h0, key_code}, 16'h0);
        check("rst_num", num, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("col_rotate", {12'h0, col}, {12'h0, tb_col(((i + 1) / 4) % 4)});
        end
        check("idle_no_pulse", 16'(pulses), 16'd0);

        expect_key(4'h6);
        press(1, 2, 10, 1'b0);
        check("num_6", num, 16'h0006);

        expect_key(4'h1); press(0, 1, 10, 1'b0);
        expect_key(4'hA); press(2, 2, 10, 1'b0);
        expect_key(4'h3); press(0, 3, 10, 1'b0);
        expect_key(4'hF); press(3, 3, 10, 1'b0);
        check("num_1A3F", num, 16'h1A3F);
        expect_key(4'h5); press(1, 1, 10, 1'b0);
        check("num_A3F5", num, 16'hA3F5);

        // Bouncy press and bouncy release of key 7.
        p0 = pulses;
        expect_key(4'h7);
        for (int i = 0; i < 7; i++) begin
            keys[7] = ~keys[7];
            repeat (3) @(negedge clk);
        end
        keys[7] = 1'b1;
        wait_pulse(300, at);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            keys[7] = ~keys[7];
            repeat (3) @(negedge clk);
        end
        keys[7] = 1'b0;
        repeat (40) @(negedge clk);
        check("bounce_pulses", 16'(pulses - p0), 16'd1);
        check("num_3F57", num, 16'h3F57);

        // Two keys in the same column are ignored.
        p0 = pulses;
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        repeat (100) @(negedge clk);
        keys = 16'h0;
        repeat (30) @(negedge clk);
        check("multi_no_pulse", 16'(pulses - p0), 16'd0);
        check("multi_num", num, 16'h3F57);

        // clr on the pulse cycle wins over the shift; key_code still updates.
        exp_num = 16'h0;
        sb.push_back({4'h2, 16'h0000});
        press(0, 2, 10, 1'b1);
        check("clr_num", num, 16'h0);
        check("clr_code", {12'h0, key_code}, 16'h0002);

        // Reset while key 9 is held, then expect one fresh pulse.
        expect_key(4'h9);
        wait_col(tb_col(2));
        keys[9] = 1'b1;
        wait_pulse(100, at);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("hrst_col", {12'h0, col}, 16'h0007);
        check("hrst_valid", {15'h0, key_valid}, 16'h0);
        check("hrst_code", {12'h0, key_code}, 16'h0);
        check("hrst_num", num, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        exp_num = 16'h0;
        expect_key(4'h9);
        wait_pulse(100, at);
        repeat (20) @(negedge clk);
        keys = 16'h0;
        repeat (40) @(negedge clk);
        check("hrst_pulses", 16'(pulses - p0), 16'd1);
        check("num_0009", num, 16'h0009);

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
